// File: rtl/clk_step_ctrl.sv
// Clock-step controller: halts, single-steps and resumes the CPU clock divider from NIOS commands.
// Optional CLK_STEP_BREAK_EN adds a break_hit input that forces a halt while running.
module clk_step_ctrl #(
    parameter int PULSE_HIGH = 2,
    parameter int PULSE_LOW  = 2,
    parameter int GUARD      = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             reset,
`ifdef CLK_STEP_BREAK_EN
    input  logic             break_hit,
`endif
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_code,
    input  logic [CNT_W-1:0] step_count,
    output logic             cmd_ready,
    output logic             cmd_err,
    output logic             clk_source_sel,
    output logic             clk_step_out,
    output logic             busy,
    output logic [CNT_W-1:0] steps_done
);
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_HALT = 2'd2;
    localparam logic [1:0] CMD_STEP = 2'd3;

    localparam int TMAX = (GUARD > PULSE_HIGH) ? ((GUARD > PULSE_LOW) ? GUARD : PULSE_LOW)
                                               : ((PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW);
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] G_LD  = TW'(GUARD - 1);
    localparam logic [TW-1:0] PH_LD = TW'(PULSE_HIGH - 1);
    localparam logic [TW-1:0] PL_LD = TW'(PULSE_LOW - 1);

    typedef enum logic [2:0] {
        S_RUN, S_GUARD_IN, S_HALTED, S_STEP_HI, S_STEP_LO, S_GUARD_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             err_d;
    logic             sel_q, step_q, rdy_q, busy_q, err_q;
    logic             brk, accept, rdy_d;

`ifdef CLK_STEP_BREAK_EN
    assign brk = break_hit && (state_q == S_RUN);
`else
    assign brk = 1'b0;
`endif

    // A break in RUN masks ready in the same cycle so a concurrent command cannot slip in.
    assign cmd_ready = rdy_q && !brk;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        done_d  = done_q;
        err_d   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (brk || (accept && cmd_code == CMD_HALT)) begin
                    state_d = S_GUARD_IN;
                    tmr_d   = G_LD;
                end else if (accept && cmd_code == CMD_STEP) begin
                    err_d = 1'b1;
                end
            end
            S_GUARD_IN: begin
                if (tmr_q == '0) state_d = S_HALTED;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_HALTED: begin
                if (accept && cmd_code == CMD_STEP && step_count != '0) begin
                    state_d = S_STEP_HI;
                    rem_d   = step_count;
                    tmr_d   = PH_LD;
                end else if (accept && cmd_code == CMD_RUN) begin
                    state_d = S_GUARD_OUT;
                    tmr_d   = G_LD;
                end
            end
            S_STEP_HI: begin
                if (tmr_q == '0) begin
                    state_d = S_STEP_LO;
                    tmr_d   = PL_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_STEP_LO: begin
                if (tmr_q == '0) begin
                    done_d = done_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_STEP_HI;
                        tmr_d   = PH_LD;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GUARD_OUT: begin
                if (tmr_q == '0) state_d = S_RUN;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign rdy_d = (state_d == S_RUN) || (state_d == S_HALTED);

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            tmr_q   <= '0;
            rem_q   <= '0;
            done_q  <= '0;
            sel_q   <= 1'b0;
            step_q  <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            sel_q   <= (state_d != S_RUN);
            step_q  <= (state_d == S_STEP_HI);
            rdy_q   <= rdy_d;
            busy_q  <= !rdy_d;
            err_q   <= err_d;
        end
    end

    assign cmd_err        = err_q;
    assign clk_source_sel = sel_q;
    assign clk_step_out   = step_q;
    assign busy           = busy_q;
    assign steps_done     = done_q;
endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl: reset, vector table, hand timing sequences, wrap on a
// narrow instance, async reset mid-pulse, and randomized commands against a timeline model.
module tb_clk_step_ctrl;
    localparam int PH = 2, PL = 2, G = 4, W = 16;
    localparam logic [1:0] NOP = 2'd0, RUN = 2'd1, HALT = 2'd2, STEP = 2'd3;

    logic         clk_in = 1'b0, reset = 1'b0;
    logic         cmd_valid = 1'b0, break_hit = 1'b0;
    logic [1:0]   cmd_code = 2'd0;
    logic [W-1:0] step_count = '0;
    logic         cmd_ready, cmd_err, clk_source_sel, clk_step_out, busy;
    logic [W-1:0] steps_done;

    logic         s_reset = 1'b0, s_valid = 1'b0;
    logic [1:0]   s_code = 2'd0;
    logic [3:0]   s_cnt = 4'd0;
    logic         s_rdy, s_err, s_sel, s_step, s_busy;
    logic [3:0]   s_done;

    int checks = 0, errors = 0;

    always #10 clk_in = ~clk_in;

    clk_step_ctrl #(.PULSE_HIGH(PH), .PULSE_LOW(PL), .GUARD(G), .CNT_W(W)) dut (
        .clk_in(clk_in), .reset(reset),
`ifdef CLK_STEP_BREAK_EN
        .break_hit(break_hit),
`endif
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .step_count(step_count),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err), .clk_source_sel(clk_source_sel),
        .clk_step_out(clk_step_out), .busy(busy), .steps_done(steps_done)
    );

    // Narrow, fast instance so the counter wrap is reachable in a short run.
    clk_step_ctrl #(.PULSE_HIGH(1), .PULSE_LOW(1), .GUARD(1), .CNT_W(4)) dut_s (
        .clk_in(clk_in), .reset(s_reset),
`ifdef CLK_STEP_BREAK_EN
        .break_hit(1'b0),
`endif
        .cmd_valid(s_valid), .cmd_code(s_code), .step_count(s_cnt),
        .cmd_ready(s_rdy), .cmd_err(s_err), .clk_source_sel(s_sel),
        .clk_step_out(s_step), .busy(s_busy), .steps_done(s_done)
    );

    typedef struct packed {
        logic err, sel, step, rdy;
        logic [W-1:0] done;
    } out_t;

    typedef struct {
        logic v; logic [1:0] code; logic [W-1:0] cnt;
        logic sel, step, rdy, err;
    } vec_t;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return {11'd0, cmd_err, clk_source_sel, clk_step_out, cmd_ready, busy, steps_done};
    endfunction

    function automatic logic [31:0] want(input out_t e);
        return {11'd0, e.err, e.sel, e.step, e.rdy, !e.rdy, e.done};
    endfunction

    function automatic out_t mk_o(input logic e, s, st, r, input logic [W-1:0] d);
        out_t o;
        o.err = e; o.sel = s; o.step = st; o.rdy = r; o.done = d;
        return o;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [1:0] c, input logic [W-1:0] n,
                                 input logic s, st, r, e);
        vec_t x;
        x.v = v; x.code = c; x.cnt = n; x.sel = s; x.step = st; x.rdy = r; x.err = e;
        return x;
    endfunction

    task automatic s_cmd(input logic [1:0] c, input logic [3:0] n, output int lat);
        s_valid = 1'b1; s_code = c; s_cnt = n;
        tick();
        s_valid = 1'b0;
        lat = 1;
        while (!s_rdy && lat < 200) begin tick(); lat++; end
    endtask

    // Reference model: an accepted command expands into the list of per-cycle outputs it causes.
    out_t         mq[$];
    out_t         cur;
    logic         m_halted;
    logic [W-1:0] m_done;

    function automatic out_t idle();
        return mk_o(1'b0, m_halted, 1'b0, 1'b1, m_done);
    endfunction

    task automatic model_accept(input logic [1:0] c, input logic [W-1:0] n);
        if (!m_halted) begin
            if (c == HALT) begin
                repeat (G) mq.push_back(mk_o(1'b0, 1'b1, 1'b0, 1'b0, m_done));
                m_halted = 1'b1;
            end else if (c == STEP) begin
                mq.push_back(mk_o(1'b1, 1'b0, 1'b0, 1'b1, m_done));
            end
        end else begin
            if (c == STEP && n != 0) begin
                for (int k = 0; k < int'(n); k++) begin
                    repeat (PH) mq.push_back(mk_o(1'b0, 1'b1, 1'b1, 1'b0, m_done));
                    repeat (PL) mq.push_back(mk_o(1'b0, 1'b1, 1'b0, 1'b0, m_done));
                    m_done = m_done + 1'b1;
                end
            end else if (c == RUN) begin
                repeat (G) mq.push_back(mk_o(1'b0, 1'b1, 1'b0, 1'b0, m_done));
                m_halted = 1'b0;
            end
        end
    endtask

    vec_t         tbl[12];
    logic [W-1:0] ed;
    logic         es;
    logic         acc;
    int           lat;

    initial begin
        // Reset: outputs asynchronously at reset values, then held for 10 cycles.
        #2 reset = 1'b1;
        #3 chk("reset_async", obs(), {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_hold", obs(), {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        end

        // Vector table: each row is one cycle's inputs and the outputs after the next edge.
        tbl[0]  = mkv(1, STEP, 16'd3, 0, 0, 1, 1);
        tbl[1]  = mkv(0, NOP,  16'd0, 0, 0, 1, 0);
        tbl[2]  = mkv(1, NOP,  16'd0, 0, 0, 1, 0);
        tbl[3]  = mkv(1, RUN,  16'd0, 0, 0, 1, 0);
        tbl[4]  = mkv(1, HALT, 16'd0, 1, 0, 0, 0);
        tbl[5]  = mkv(0, NOP,  16'd0, 1, 0, 0, 0);
        tbl[6]  = mkv(0, NOP,  16'd0, 1, 0, 0, 0);
        tbl[7]  = mkv(0, NOP,  16'd0, 1, 0, 0, 0);
        tbl[8]  = mkv(0, NOP,  16'd0, 1, 0, 1, 0);
        tbl[9]  = mkv(1, STEP, 16'd0, 1, 0, 1, 0);
        tbl[10] = mkv(1, HALT, 16'd0, 1, 0, 1, 0);
        tbl[11] = mkv(1, NOP,  16'd0, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cmd_valid = tbl[i].v; cmd_code = tbl[i].code; step_count = tbl[i].cnt;
            tick();
            chk($sformatf("table_row%0d", i), obs(),
                want(mk_o(tbl[i].err, tbl[i].sel, tbl[i].step, tbl[i].rdy, 16'h0)));
        end
        cmd_valid = 1'b0;

        // STEP 3 from HALTED: pulses at T+1-2, T+5-6, T+9-10; ready and count 3 at T+13.
        cmd_valid = 1'b1; cmd_code = STEP; step_count = 16'd3;
        for (int i = 1; i <= 13; i++) begin
            tick();
            cmd_valid = 1'b0;
            es = (i <= 12) && (((i - 1) % 4) < 2);
            ed = W'((i - 1) / 4);
            chk($sformatf("step3_T+%0d", i), {15'd0, clk_step_out, cmd_ready, clk_source_sel, ed},
                {15'd0, es, 1'(i == 13), 1'b1, steps_done});
        end

        // RUN from HALTED: prescaled clock and ready back at T+GUARD+1.
        cmd_valid = 1'b1; cmd_code = RUN;
        for (int i = 1; i <= G + 1; i++) begin
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("resume_T+%0d", i), {29'd0, clk_source_sel, cmd_ready, clk_step_out},
                {29'd0, 1'(i <= G), 1'(i == G + 1), 1'b0});
        end

        // Async reset in the middle of the first high phase of a 5-step command.
        cmd_valid = 1'b1; cmd_code = HALT;
        tick(); cmd_valid = 1'b0;
        repeat (G) tick();
        cmd_valid = 1'b1; cmd_code = STEP; step_count = 16'd5;
        tick(); cmd_valid = 1'b0;
        chk("rst5_pulse_high", {30'd0, clk_step_out, clk_source_sel}, {30'd0, 2'b11});
        #5 reset = 1'b1;
        #1 chk("rst5_immediate", obs(), {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        #2 reset = 1'b0;
        tick();
        chk("rst5_run_state", obs(), {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
        cmd_valid = 1'b1; cmd_code = STEP;
        tick(); cmd_valid = 1'b0;
        chk("rst5_step_in_run_err", {31'd0, cmd_err}, 32'd1);

        // Counter wrap on the 4-bit instance: preload 14, then STEP 3 lands on 1.
        s_reset = 1'b1; tick(); s_reset = 1'b0; tick();
        s_cmd(HALT, 4'd0, lat);
        chk("wrap_halt_latency", lat, 2);
        s_cmd(STEP, 4'd14, lat);
        chk("wrap_step14_latency", lat, 29);
        chk("wrap_preload", {28'd0, s_done}, 32'd14);
        s_cmd(STEP, 4'd3, lat);
        chk("wrap_step3_latency", lat, 7);
        chk("wrap_result", {28'd0, s_done}, 32'd1);

`ifdef CLK_STEP_BREAK_EN
        // Break in RUN with a concurrent RUN command: command blocked, halt path taken.
        reset = 1'b1; #2 reset = 1'b0; tick();
        break_hit = 1'b1; cmd_valid = 1'b1; cmd_code = RUN;
        #1 chk("brk_ready_masked", {31'd0, cmd_ready}, 32'd0);
        tick();
        break_hit = 1'b0; cmd_valid = 1'b0;
        chk("brk_guard_in", {30'd0, clk_source_sel, cmd_ready}, {30'd0, 2'b10});
        repeat (G) tick();
        chk("brk_halted", {30'd0, clk_source_sel, cmd_ready}, {30'd0, 2'b11});
        cmd_valid = 1'b1; cmd_code = STEP; step_count = 16'd1;
        tick(); cmd_valid = 1'b0;
        chk("brk_step_pulse", {31'd0, clk_step_out}, 32'd1);
`endif

        // Randomized commands against the timeline model.
        reset = 1'b1; #2 reset = 1'b0; tick();
        mq.delete();
        m_halted = 1'b0; m_done = '0;
        cur = idle();
        chk("rand_start", obs(), want(cur));
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_code   = 2'($urandom_range(0, 3));
            step_count = W'($urandom_range(0, 3));
            acc = cmd_valid && cur.rdy;
            tick();
            if (acc) model_accept(cmd_code, step_count);
            cur = (mq.size() != 0) ? mq.pop_front() : idle();
            chk($sformatf("rand_cyc%0d", i), obs(), want(cur));
        end
        cmd_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
